shift_issue_stage: RTL

Pipeline stage directly upstream of `barrelshifter32`. It accepts decoded-execute requests (instruction word plus register operands), recognises RV32I shift instructions, and produces the registered operand, shift amount, direction bit and arithmetic flag that drive the shifter's `i`, `s`, `func3` and `is_sra` inputs. A two-entry skid buffer gives full throughput with a registered `in_ready`. Non-shift instructions are consumed and dropped; malformed shift encodings are forwarded with an illegal flag.

---
 rtl/shift_issue_stage_pkg.sv | 28 ++
 rtl/shift_issue_stage_decode.sv | 50 +++++
 rtl/shift_issue_stage.sv | 120 ++++++++++++
 3 files changed

// File: rtl/shift_issue_stage_pkg.sv
// Shared encodings, buffer state and entry layout for the shift issue stage.
package shift_issue_stage_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  amt;
        logic        left;
        logic        arith;
        logic [4:0]  rd;
        logic        illegal;
    } shift_entry_t;

endpackage

// File: rtl/shift_issue_stage_decode.sv
// Combinational RV32I shift decoder: instruction plus operands to an issue entry.
module shift_decode
    import shift_issue_stage_pkg::*;
(
    input  logic [31:0]  instr_i,
    input  logic [31:0]  rs1_i,
    input  logic [4:0]   rs2_amt_i,
    output shift_entry_t entry_o,
    output logic         is_shift_o
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       illegal;
    logic [4:0] rs1_field_unused;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];
    assign rs1_field_unused = instr_i[19:15];

    always_comb begin
        is_shift_o = 1'b0;
        if ((opc == OPC_OP) || (opc == OPC_OP_IMM)) begin
            is_shift_o = (f3 == F3_SLL) || (f3 == F3_SRL_SRA);
        end
    end

    // f7 bit 0 doubles as shamt[5] for immediates, so SLLI/SRAI with it set fall out here
    always_comb begin
        illegal = 1'b0;
        if (f3 == F3_SRL_SRA) begin
            illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
        end else begin
            illegal = (f7 != F7_BASE);
        end
    end

    always_comb begin
        entry_o         = '0;
        entry_o.data    = rs1_i;
        entry_o.amt     = (opc == OPC_OP) ? rs2_amt_i : instr_i[24:20];
        entry_o.left    = ~f3[2];
        entry_o.arith   = f3[2] & instr_i[30] & ~illegal;
        entry_o.rd      = instr_i[11:7];
        entry_o.illegal = illegal;
    end

endmodule

// File: rtl/shift_issue_stage.sv
// Shift issue stage: decodes shifts and buffers them in a two-entry skid buffer feeding the shifter.
module shift_issue_stage
    import shift_issue_stage_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [4:0]       out_amt,
    output logic             out_left,
    output logic             out_arith,
    output logic [4:0]       out_rd,
    output logic             out_illegal,
    output logic [CNT_W-1:0] shift_count
);

    state_t       state_q, state_d;
    shift_entry_t main_q, main_d;
    shift_entry_t skid_q, skid_d;
    logic         in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    shift_entry_t dec_entry;
    logic         dec_is_shift;
    logic         accept;
    logic         drain;
    logic [26:0]  rs2_hi_unused;

    assign rs2_hi_unused = in_rs2[31:5];

    shift_decode u_decode (
        .instr_i    (in_instr),
        .rs1_i      (in_rs1),
        .rs2_amt_i  (in_rs2[4:0]),
        .entry_o    (dec_entry),
        .is_shift_o (dec_is_shift)
    );

    // Non-shifts still handshake with upstream; they just never reach a slot.
    assign accept = in_valid & in_ready_q & dec_is_shift;
    assign drain  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_d  = dec_entry;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    main_d = dec_entry;
                end else if (accept) begin
                    state_d = ST_FULL;
                    skid_d  = dec_entry;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end
        in_ready_d = (state_d != ST_FULL);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (drain && !main_q.illegal) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != ST_EMPTY);
    assign out_data    = main_q.data;
    assign out_amt     = main_q.amt;
    assign out_left    = main_q.left;
    assign out_arith   = main_q.arith;
    assign out_rd      = main_q.rd;
    assign out_illegal = main_q.illegal;
    assign shift_count = cnt_q;

endmodule
